// File: rtl/midpoint_pkg.sv
// rtl/midpoint_pkg.sv - shared types and defaults for the midpoint interpolator
package midpoint_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        NOPREV = 2'd0,
        READY  = 2'd1,
        MID    = 2'd2,
        SMP    = 2'd3
    } state_t;

endpackage

// File: rtl/midpoint_interpolator_if.sv
// rtl/midpoint_interpolator_if.sv - input and output sample streams of the interpolator
interface midpoint_interpolator_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_mid;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_mid
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_mid
    );
endinterface

// File: rtl/midpoint_round_up.sv
// rtl/midpoint_round_up.sv - rounded-up midpoint of two unsigned samples
module midpoint_round_up #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] m
);
    logic [WIDTH:0] sum;

    // One extra bit holds the carry, so the shifted result always fits back in WIDTH.
    assign sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, 1'b1};
    assign m   = sum[WIDTH:1];
endmodule

// File: rtl/midpoint_interpolator.sv
// rtl/midpoint_interpolator.sv - 2x upsampler inserting rounded-up midpoints between samples
module midpoint_interpolator
    import midpoint_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  restart,
    midpoint_interpolator_if.slave bus
);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             out_mid_q, out_mid_d;
    logic [WIDTH-1:0] mid_val;
    logic             in_ready;
    logic             in_xfer;

    midpoint_round_up #(.WIDTH(WIDTH)) u_round_up (
        .a (prev_q),
        .b (bus.in_data),
        .m (mid_val)
    );

    // In MID the output slot is taken and pend is occupied, so nothing can be accepted.
    assign in_ready = !restart && ((state_q == NOPREV) || (state_q == READY) ||
                                   ((state_q == SMP) && bus.out_ready));
    assign in_xfer  = bus.in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        pend_d      = pend_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_mid_d   = out_mid_q;
        if (restart) begin
            state_d     = NOPREV;
            out_valid_d = 1'b0;
            out_mid_d   = 1'b0;
        end else begin
            case (state_q)
                NOPREV: if (in_xfer) begin
                    out_data_d  = bus.in_data;
                    out_mid_d   = 1'b0;
                    out_valid_d = 1'b1;
                    prev_d      = bus.in_data;
                    state_d     = SMP;
                end
                READY: if (in_xfer) begin
                    out_data_d  = mid_val;
                    out_mid_d   = 1'b1;
                    out_valid_d = 1'b1;
                    pend_d      = bus.in_data;
                    state_d     = MID;
                end
                MID: if (bus.out_ready) begin
                    out_data_d = pend_q;
                    out_mid_d  = 1'b0;
                    prev_d     = pend_q;
                    state_d    = SMP;
                end
                SMP: if (bus.out_ready) begin
                    if (in_xfer) begin
                        out_data_d = mid_val;
                        out_mid_d  = 1'b1;
                        pend_d     = bus.in_data;
                        state_d    = MID;
                    end else begin
                        out_valid_d = 1'b0;
                        state_d     = READY;
                    end
                end
                default: state_d = NOPREV;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= NOPREV;
            prev_q      <= '0;
            pend_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_mid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            pend_q      <= pend_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_mid_q   <= out_mid_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_mid   = out_mid_q;
endmodule

// File: tb/tb_midpoint_interpolator.sv
// tb/tb_midpoint_interpolator.sv - randomized scoreboard bench for midpoint_interpolator
module tb_midpoint_interpolator;

    typedef struct {
        logic [7:0] d;
        logic       mid;
    } item_t;

    logic clk;
    logic rst;
    logic restart;
    logic rnd_ready;

    int n_vec;
    int n_err;

    item_t expq[$];
    item_t got[$];
    bit    hist;
    int    mprev;

    logic [7:0] ea, eb, em;

    midpoint_interpolator_if #(.WIDTH(8)) ifc ();

    midpoint_interpolator #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .bus     (ifc)
    );

    midpoint_round_up #(.WIDTH(8)) u_ref_round (
        .a (ea),
        .b (eb),
        .m (em)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Reference: each accepted sample yields midpoint-with-history (if any), then the sample.
    always @(negedge clk) begin
        if (rst || restart) begin
            hist = 1'b0;
            expq.delete();
        end else begin
            if (ifc.out_valid && ifc.out_ready) begin
                item_t e;
                item_t g;
                g.d   = ifc.out_data;
                g.mid = ifc.out_mid;
                got.push_back(g);
                chk("out_expected", 32'(expq.size() != 0), 1);
                if (expq.size() != 0) begin
                    e = expq.pop_front();
                    chk("out_data", 32'(g.d), 32'(e.d));
                    chk("out_mid", 32'(g.mid), 32'(e.mid));
                end
            end
            if (ifc.in_valid && ifc.in_ready) begin
                item_t n;
                if (hist) begin
                    n.d   = 8'((mprev + int'(ifc.in_data) + 1) / 2);
                    n.mid = 1'b1;
                    expq.push_back(n);
                end
                n.d   = ifc.in_data;
                n.mid = 1'b0;
                expq.push_back(n);
                mprev = int'(ifc.in_data);
                hist  = 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        #2;
        if (rnd_ready) ifc.out_ready = 1'($urandom_range(0, 1));
    end

    task automatic send(input logic [7:0] x);
        int   c;
        logic acc;
        c   = 0;
        acc = 1'b0;
        ifc.in_valid = 1'b1;
        ifc.in_data  = x;
        while (!acc && c < 500) begin
            @(negedge clk);
            acc = ifc.in_ready;
            @(posedge clk);
            #1;
            c++;
        end
        ifc.in_valid = 1'b0;
        chk("send_accept", 32'(acc), 1);
    endtask

    task automatic wait_got(input int n);
        int c;
        c = 0;
        while (got.size() < n && c < 500) begin
            @(posedge clk);
            c++;
        end
        #1;
        chk("wait_got", 32'(got.size() >= n), 1);
    endtask

    task automatic wait_drain();
        int c;
        c = 0;
        while (expq.size() != 0 && c < 1000) begin
            @(posedge clk);
            c++;
        end
        #1;
        chk("drain", 32'(expq.size()), 0);
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(negedge clk);
        chk("ready_in_restart", 32'(ifc.in_ready), 0);
        @(posedge clk);
        #1;
        restart = 1'b0;
        chk("valid_after_restart", 32'(ifc.out_valid), 0);
    endtask

    task automatic check_seq(input string tag, input int d0, input int d1, input int d2,
                             input int d3, input int d4);
        int exp_d[5];
        exp_d = '{d0, d1, d2, d3, d4};
        wait_got(5);
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            chk({tag, "_data"}, 32'(got[i].d), 32'(exp_d[i]));
            chk({tag, "_mid"}, 32'(got[i].mid), 32'(i % 2));
        end
    endtask

    initial begin
        n_vec         = 0;
        n_err         = 0;
        hist          = 1'b0;
        mprev         = 0;
        rst           = 1'b1;
        restart       = 1'b0;
        rnd_ready     = 1'b0;
        ifc.in_valid  = 1'b0;
        ifc.in_data   = '0;
        ifc.out_ready = 1'b1;
        ea            = '0;
        eb            = '0;
        #23;
        chk("rst_out_valid", 32'(ifc.out_valid), 0);
        chk("rst_out_mid", 32'(ifc.out_mid), 0);
        chk("rst_out_data", 32'(ifc.out_data), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_ready", 32'(ifc.in_ready), 1);

        // Basic sequence and saturation corner
        got.delete();
        send(8'd10); send(8'd20); send(8'd21);
        check_seq("seq_a", 10, 15, 20, 21, 21);
        wait_drain();
        pulse_restart();
        got.delete();
        send(8'd255); send(8'd255); send(8'd0);
        check_seq("seq_b", 255, 255, 255, 128, 0);
        wait_drain();

        // Back-pressure while a midpoint is on the output
        pulse_restart();
        send(8'd30);
        send(8'd60);
        ifc.out_ready = 1'b0;
        ifc.in_valid  = 1'b1;
        ifc.in_data   = 8'd99;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(ifc.out_valid), 1);
            chk("hold_data", 32'(ifc.out_data), 45);
            chk("hold_mid", 32'(ifc.out_mid), 1);
            chk("hold_in_ready", 32'(ifc.in_ready), 0);
            @(posedge clk);
            #1;
        end
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_data", 32'(ifc.out_data), 60);
        chk("release_mid", 32'(ifc.out_mid), 0);
        wait_drain();

        // Restart drops the pending sample and the history
        pulse_restart();
        send(8'd30);
        send(8'd40);
        pulse_restart();
        got.delete();
        send(8'd50);
        wait_got(1);
        if (got.size() > 0) begin
            chk("restart_data", 32'(got[0].d), 50);
            chk("restart_mid", 32'(got[0].mid), 0);
        end
        wait_drain();

        // Async reset while a sample sits unconsumed
        pulse_restart();
        ifc.out_ready = 1'b0;
        send(8'd70);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(ifc.out_valid), 0);
        chk("arst_mid", 32'(ifc.out_mid), 0);
        chk("arst_data", 32'(ifc.out_data), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ifc.out_ready = 1'b1;
        got.delete();
        send(8'd80);
        wait_got(1);
        if (got.size() > 0) begin
            chk("arst_first_data", 32'(got[0].d), 80);
            chk("arst_first_mid", 32'(got[0].mid), 0);
        end
        wait_drain();

        // Random pairs after restart with random back-pressure
        rnd_ready = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            pulse_restart();
            send(8'($urandom_range(0, 255)));
            send(8'($urandom_range(0, 255)));
            wait_drain();
        end

        // Continuous random stream with idle gaps
        pulse_restart();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send(8'($urandom_range(0, 255)));
        end
        wait_drain();
        rnd_ready = 1'b0;

        // Every operand pair through the rounding unit
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                ea = 8'(a);
                eb = 8'(b);
                #1;
                chk("mid_exhaustive", 32'(em), 32'((a + b + 1) / 2));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
